// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor, one BLK-bit group per stage.
// Valid/ready handshake with bubble collapse; last stage is the output register.
module cla_pipe_addsub #(
    parameter int W   = 16,
    parameter int BLK = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_cin,
    input  logic [1:0]   in_op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sum,
    output logic         out_cout,
    output logic         out_ovf,
    output logic         out_zero
);
    localparam int NGRP = W / BLK;

    logic [NGRP-1:0] vld;
    logic [NGRP-1:0] rdy;
    logic [W-1:0]    a_q [NGRP];
    logic [W-1:0]    b_q [NGRP];
    logic [W-1:0]    s_q [NGRP];
    logic [NGRP-1:0] c_q;
    logic            ovf_q;
    logic            zero_q;

    logic [W-1:0]    src_a [NGRP];
    logic [W-1:0]    src_b [NGRP];
    logic [W-1:0]    src_s [NGRP];
    logic [W-1:0]    nxt_s [NGRP];
    logic [NGRP-1:0] src_c;
    logic [NGRP-1:0] src_v;
    logic [NGRP-1:0] nxt_c;
    logic            msb_c;

    logic [W-1:0]    b_eff;
    logic            c0;
    logic            unused;

    // Returns {carry into group MSB, group carry out, group sum}.
    function automatic logic [BLK+1:0] grp(
        input logic [BLK-1:0] a,
        input logic [BLK-1:0] b,
        input logic           cin
    );
        logic [BLK:0] c;
        logic         gg;
        logic         pp;
        c[0] = cin;
        for (int i = 1; i <= BLK; i++) begin
            gg = 1'b0;
            pp = 1'b1;
            for (int j = 0; j < i; j++) begin
                gg = (a[j] & b[j]) | ((a[j] | b[j]) & gg);
                pp = pp & (a[j] | b[j]);
            end
            c[i] = gg | (pp & cin);
        end
        return {c[BLK-1], c[BLK], a ^ b ^ c[BLK-1:0]};
    endfunction

    assign b_eff = (in_op[0] ^ in_op[1]) ? ~in_b : in_b;
    assign c0    = (in_op == 2'b01) ? 1'b1 : in_cin;

    // A stage may load if any stage at or after it is empty, or the output drains.
    always_comb begin
        logic acc;
        acc = out_ready;
        rdy = '0;
        for (int j = NGRP - 1; j >= 0; j--) begin
            acc    = acc | ~vld[j];
            rdy[j] = acc;
        end
    end

    always_comb begin
        logic [BLK+1:0] r;
        r        = '0;
        msb_c    = 1'b0;
        nxt_c    = '0;
        src_c    = '0;
        src_v    = '0;
        src_a[0] = in_a;
        src_b[0] = b_eff;
        src_s[0] = '0;
        src_c[0] = c0;
        src_v[0] = in_valid;
        for (int j = 1; j < NGRP; j++) begin
            src_a[j] = a_q[j-1];
            src_b[j] = b_q[j-1];
            src_s[j] = s_q[j-1];
            src_c[j] = c_q[j-1];
            src_v[j] = vld[j-1];
        end
        for (int j = 0; j < NGRP; j++) begin
            r = grp(src_a[j][j*BLK +: BLK],
                    src_b[j][j*BLK +: BLK],
                    src_c[j]);
            nxt_s[j] = src_s[j];
            nxt_s[j][j*BLK +: BLK] = r[BLK-1:0];
            nxt_c[j] = r[BLK];
            if (j == NGRP - 1) msb_c = r[BLK+1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld    <= '0;
            c_q    <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            for (int j = 0; j < NGRP; j++) begin
                a_q[j] <= '0;
                b_q[j] <= '0;
                s_q[j] <= '0;
            end
        end else begin
            for (int j = 0; j < NGRP; j++) begin
                if (rdy[j]) begin
                    vld[j] <= src_v[j];
                    if (src_v[j]) begin
                        a_q[j] <= src_a[j];
                        b_q[j] <= src_b[j];
                        s_q[j] <= nxt_s[j];
                        c_q[j] <= nxt_c[j];
                    end
                end
            end
            if (rdy[NGRP-1] && src_v[NGRP-1]) begin
                ovf_q  <= msb_c ^ nxt_c[NGRP-1];
                zero_q <= (nxt_s[NGRP-1] == '0);
            end
        end
    end

    assign unused    = ^{a_q[NGRP-1], b_q[NGRP-1]};
    assign in_ready  = rdy[0];
    assign out_valid = vld[NGRP-1];
    assign out_sum   = s_q[NGRP-1];
    assign out_cout  = c_q[NGRP-1];
    assign out_ovf   = ovf_q;
    assign out_zero  = zero_q;
endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Scoreboard bench for cla_pipe_addsub (W=16, BLK=4).
// Driver pushes reference results; a negedge monitor compares in order.
module tb_cla_pipe_addsub;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        in_cin = 1'b0;
    logic [1:0]  in_op = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_sum;
    logic        out_cout;
    logic        out_ovf;
    logic        out_zero;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   last_out = 0;
    bit   seen = 0;
    bit   rmode = 0;

    cla_pipe_addsub #(.W(16), .BLK(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b),
        .in_cin(in_cin), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout),
        .out_ovf(out_ovf), .out_zero(out_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t mk(
        logic [15:0] s, logic co, logic ov, logic z
    );
        exp_t e;
        e.sum = s; e.cout = co; e.ovf = ov; e.zero = z;
        e.lat = 4; e.acc = 0;
        return e;
    endfunction

    // Plain-arithmetic reference for a + b_eff + c0.
    function automatic exp_t model(
        logic [1:0] op, logic [15:0] a, logic [15:0] b, logic c
    );
        exp_t        e;
        logic [15:0] be;
        logic [16:0] full;
        int          sa, sb, ss;
        be   = (op == 2'b01 || op == 2'b10) ? ~b : b;
        full = {1'b0, a} + {1'b0, be} + ((op == 2'b01) ? 17'd1 : {16'd0, c});
        e.sum  = full[15:0];
        e.cout = full[16];
        sa = a[15]; sb = be[15]; ss = full[15];
        e.ovf  = (sa == sb) && (ss != sa);
        e.zero = (full[15:0] == 16'd0);
        e.lat  = -1;
        e.acc  = 0;
        return e;
    endfunction

    task automatic check(string name, int act, int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic send(
        input logic [1:0] op, input logic [15:0] a,
        input logic [15:0] b, input logic c,
        input exp_t e, output int acc
    );
        bit ok = 0;
        acc = -1;
        in_valid = 1'b1; in_op = op;
        in_a = a; in_b = b; in_cin = c;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            if (in_ready) begin
                e.acc = cyc;
                acc = cyc;
                q.push_back(e);
                ok = 1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) check("accept_timeout", 0, 1);
    endtask

    task automatic send_rnd(output int acc);
        logic [1:0]  op;
        logic [15:0] a, b;
        logic        c;
        op = 2'($urandom_range(0, 3));
        a  = 16'($urandom);
        b  = 16'($urandom);
        c  = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 7) == 0) b = ~a;
        send(op, a, b, c, model(op, a, b, c), acc);
    endtask

    task automatic drain();
        for (int t = 0; t < 400 && q.size() > 0; t++) @(posedge clk);
        #1;
        check("drain_left", q.size(), 0);
    endtask

    task automatic check_reset_state();
        @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_fields",
              int'({out_sum, out_cout, out_ovf, out_zero}), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL spurious: out_sum=%h with empty scoreboard", out_sum);
            end else begin
                tests++;
                if ({out_sum, out_cout, out_ovf, out_zero} !==
                    {q[0].sum, q[0].cout, q[0].ovf, q[0].zero}) begin
                    fails++;
                    $display("FAIL result: got sum=%h c=%b v=%b z=%b expected sum=%h c=%b v=%b z=%b",
                             out_sum, out_cout, out_ovf, out_zero,
                             q[0].sum, q[0].cout, q[0].ovf, q[0].zero);
                end
                if (!seen && q[0].lat >= 0) begin
                    tests++;
                    if (cyc - q[0].acc != q[0].lat) begin
                        fails++;
                        $display("FAIL latency: got %0d expected %0d",
                                 cyc - q[0].acc, q[0].lat);
                    end
                end
                seen = 1;
                if (out_ready) begin
                    void'(q.pop_front());
                    seen = 0;
                    last_out = cyc;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rmode) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        int acc, first;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check_reset_state();
        @(posedge clk); #1;

        send(2'b00, 16'hFFFF, 16'h0001, 1'b0, mk(16'h0000, 1, 0, 1), acc);
        drain();
        send(2'b00, 16'h7FFF, 16'h0001, 1'b0, mk(16'h8000, 0, 1, 0), acc);
        drain();
        send(2'b01, 16'h0005, 16'h0007, 1'b1, mk(16'hFFFE, 0, 0, 0), acc);
        drain();
        send(2'b10, 16'h0010, 16'h0001, 1'b0, mk(16'h000E, 1, 0, 0), acc);
        drain();
        send(2'b11, 16'h0001, 16'h0002, 1'b1, mk(16'h0004, 0, 0, 0), acc);
        drain();
        send(2'b00, 16'h8000, 16'h8000, 1'b0, mk(16'h0000, 1, 1, 1), acc);
        drain();

        send_rnd(first);
        for (int i = 1; i < 64; i++) send_rnd(acc);
        drain();
        check("stream_span", last_out - first, 67);

        fork
            begin
                for (int i = 0; i < 16; i++) send_rnd(acc);
            end
            begin
                repeat (8) @(posedge clk);
                #1 out_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check("stall_in_ready", int'(in_ready), 0);
                    @(posedge clk);
                    #1;
                    if (k == 2) out_ready = 1'b1;
                end
            end
        join
        drain();

        rmode = 1;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clk);
                #1;
            end
            send_rnd(acc);
        end
        drain();
        rmode = 0;
        out_ready = 1'b1;

        for (int i = 0; i < 3; i++) send_rnd(acc);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("reset_kill_valid", int'(out_valid), 0);
        q.delete();
        seen = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check_reset_state();
        @(posedge clk); #1;
        send(2'b00, 16'h1234, 16'h1111, 1'b0, mk(16'h2345, 0, 0, 0), acc);
        drain();
        repeat (10) @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
